// File: rtl/mem_acc_pkg.sv
// Shared constants and FSM state type for the data-memory access controller.
package mem_acc_pkg;
   localparam int unsigned ADDR_W    = 13;
   localparam int unsigned DATA_W    = 18;
   localparam int unsigned MEM_DEPTH = 13;
   localparam int unsigned MAX_LEN   = 8;
   localparam int unsigned LEN_W     = 3;

   typedef enum logic [1:0] {
      IDLE,
      RD_ISSUE,
      RD_DRAIN,
      WR
   } state_e;
endpackage

// File: rtl/mem_acc_rsp_pipe.sv
// Read-response pipeline: two-stage {valid,last,err} shift matched to the
// memory's registered read latency, plus the rsp_data capture register.
module mem_acc_rsp_pipe
   import mem_acc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic              issue_last,
   input  logic              issue_err,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rsp_valid,
   output logic              rsp_last,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_data
);

   logic valid_s1;
   logic last_s1;
   logic err_s1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_s1  <= 1'b0;
         last_s1   <= 1'b0;
         err_s1    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
      end else begin
         valid_s1  <= issue_valid;
         last_s1   <= issue_valid & issue_last;
         err_s1    <= issue_valid & issue_err;
         rsp_valid <= valid_s1;
         rsp_last  <= last_s1;
         rsp_err   <= err_s1;
         // mem_rdata is only meaningful one cycle after an issued beat
         if (valid_s1) begin
            rsp_data <= err_s1 ? '0 : mem_rdata;
         end
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: single-word writes and 1-8 word incrementing reads.
// Optional address bounds check enabled by defining MEM_ACC_BOUNDS_EN.
module mem_access_ctrl
   import mem_acc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              rsp_err,
   output logic              wr_done,
   output logic              mem_re,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adrs,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e            state;
   state_e            state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt;
   logic [DATA_W-1:0] wdata_q;
   logic              in_range;
   logic              issue_valid;
   logic              issue_last;
   logic              pipe_err;

`ifdef MEM_ACC_BOUNDS_EN
   logic wr_err;
   assign in_range = 32'(addr_q) < MEM_DEPTH;
   assign rsp_err  = pipe_err | wr_err;
`else
   assign in_range = 1'b1;
   assign rsp_err  = pipe_err;
`endif

   assign issue_last = (cnt == len_q);
   assign mem_adrs   = addr_q;
   assign mem_wdata  = wdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (req_valid) state_nxt = req_we ? WR : RD_ISSUE;
         RD_ISSUE: if (issue_last) state_nxt = RD_DRAIN;
         // leave once the final beat is on the response outputs
         RD_DRAIN: if (rsp_last) state_nxt = IDLE;
         WR:       state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready   = (state == IDLE) && !rst;
      issue_valid = (state == RD_ISSUE);
      mem_re      = (state == RD_ISSUE) && in_range;
      mem_we      = (state == WR) && in_range;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         len_q   <= '0;
         cnt     <= '0;
         wdata_q <= '0;
         wr_done <= 1'b0;
`ifdef MEM_ACC_BOUNDS_EN
         wr_err  <= 1'b0;
`endif
      end else begin
         wr_done <= (state == WR);
`ifdef MEM_ACC_BOUNDS_EN
         wr_err  <= (state == WR) && !in_range;
`endif
         if (state == IDLE && req_valid) begin
            addr_q <= req_addr;
            len_q  <= req_we ? '0 : req_len;
            cnt    <= '0;
            if (req_we) begin
               wdata_q <= req_wdata;
            end
         end else if (state == RD_ISSUE) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt    <= cnt + LEN_W'(1);
         end
      end
   end

   mem_acc_rsp_pipe u_rsp_pipe (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_last  (issue_last),
      .issue_err   (!in_range),
      .mem_rdata   (mem_rdata),
      .rsp_valid   (rsp_valid),
      .rsp_last    (rsp_last),
      .rsp_err     (pipe_err),
      .rsp_data    (rsp_data)
   );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: per-cycle expectation tables built from request
// rules, a simple memory, and literal checks on the directed scenarios.
module tb_mem_access_ctrl;
   import mem_acc_pkg::*;

   localparam int NC    = 4096;
   localparam int MSIZE = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [LEN_W-1:0]  req_len = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_last;
   logic              rsp_err;
   logic              wr_done;
   logic              mem_re;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_adrs;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ready_at = 0;

   logic [DATA_W-1:0] env_mem [MSIZE];
   logic [DATA_W-1:0] shadow  [MSIZE];

   bit                e_re   [NC];
   bit                e_we   [NC];
   bit                e_rv   [NC];
   bit                e_last [NC];
   bit                e_err  [NC];
   bit                e_wd   [NC];
   logic [ADDR_W-1:0] e_adrs [NC];
   logic [DATA_W-1:0] e_wdat [NC];
   logic [DATA_W-1:0] e_rdat [NC];

   logic [DATA_W-1:0] cap_d [$];
   bit                cap_l [$];
   bit                cap_e [$];
   logic [ADDR_W-1:0] cap_a [$];
   logic [ADDR_W-1:0] cap_w [$];

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_last  (rsp_last),
      .rsp_err   (rsp_err),
      .wr_done   (wr_done),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_adrs  (mem_adrs),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // single-port memory with one-cycle registered read
   always @(posedge clk) begin
      if (mem_we) env_mem[mem_adrs] <= mem_wdata;
      if (mem_re) mem_rdata <= env_mem[mem_adrs];
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic bit addr_ok(input int a);
`ifdef MEM_ACC_BOUNDS_EN
      return a < int'(MEM_DEPTH);
`else
      return 1'b1;
`endif
   endfunction

   always @(negedge clk) begin
      int c;
      c = cyc;
      if (rst) begin
         for (int k = c; k < NC; k++) begin
            e_re[k] = 0; e_we[k] = 0; e_rv[k] = 0; e_last[k] = 0; e_err[k] = 0; e_wd[k] = 0;
         end
         ready_at = 0;
         chk("rst_req_ready", 32'(req_ready), 0);
         chk("rst_rsp_valid", 32'(rsp_valid), 0);
         chk("rst_rsp_data",  32'(rsp_data), 0);
         chk("rst_rsp_last",  32'(rsp_last), 0);
         chk("rst_rsp_err",   32'(rsp_err), 0);
         chk("rst_wr_done",   32'(wr_done), 0);
         chk("rst_mem_re",    32'(mem_re), 0);
         chk("rst_mem_we",    32'(mem_we), 0);
         chk("rst_mem_adrs",  32'(mem_adrs), 0);
         chk("rst_mem_wdata", 32'(mem_wdata), 0);
      end else begin
         chk("req_ready", 32'(req_ready), 32'(c >= ready_at));
         chk("mem_re", 32'(mem_re), 32'(e_re[c]));
         chk("mem_we", 32'(mem_we), 32'(e_we[c]));
         if (e_re[c] || e_we[c]) chk("mem_adrs", 32'(mem_adrs), 32'(e_adrs[c]));
         if (e_we[c]) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdat[c]));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rv[c]));
         chk("rsp_err", 32'(rsp_err), 32'(e_err[c]));
         chk("wr_done", 32'(wr_done), 32'(e_wd[c]));
         if (e_rv[c]) begin
            chk("rsp_data", 32'(rsp_data), 32'(e_rdat[c]));
            chk("rsp_last", 32'(rsp_last), 32'(e_last[c]));
         end
         if (rsp_valid) begin
            cap_d.push_back(rsp_data);
            cap_l.push_back(rsp_last);
            cap_e.push_back(rsp_err);
         end
         if (mem_re) cap_a.push_back(mem_adrs);
         if (mem_we) cap_w.push_back(mem_adrs);
         // model: a request seen here is taken at the coming rising edge
         if (req_valid && c >= ready_at) begin
            if (req_we) begin
               int a;
               a = int'(req_addr);
               e_we[c+1]   = addr_ok(a);
               e_adrs[c+1] = req_addr;
               e_wdat[c+1] = req_wdata;
               e_wd[c+2]   = 1;
               e_err[c+2]  = !addr_ok(a);
               if (addr_ok(a)) shadow[a] = req_wdata;
               ready_at = c + 2;
            end else begin
               for (int i = 0; i <= int'(req_len); i++) begin
                  int a;
                  a = (int'(req_addr) + i) % MSIZE;
                  e_re[c+1+i]   = addr_ok(a);
                  e_adrs[c+1+i] = ADDR_W'(a);
                  e_rv[c+3+i]   = 1;
                  e_rdat[c+3+i] = addr_ok(a) ? shadow[a] : '0;
                  e_last[c+3+i] = (i == int'(req_len));
                  e_err[c+3+i]  = !addr_ok(a);
               end
               ready_at = c + int'(req_len) + 4;
            end
         end
      end
   end

   task automatic clear_caps();
      cap_d.delete(); cap_l.delete(); cap_e.delete(); cap_a.delete(); cap_w.delete();
   endtask

   task automatic send(input bit we, input int addr, input int len, input logic [DATA_W-1:0] wd);
      bit got;
      got = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = ADDR_W'(addr);
      req_len   = LEN_W'(len);
      req_wdata = wd;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL req_accept_timeout at cycle %0d: got no req_ready expected acceptance", cyc);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < MSIZE; k++) begin
         env_mem[k] = DATA_W'(k + 100);
         shadow[k]  = DATA_W'(k + 100);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      wait_n(2);

      clear_caps();
      send(0, 2, 3, '0);
      wait_n(10);
      chk("burst_beats", 32'(cap_d.size()), 4);
      for (int i = 0; i < 4; i++) begin
         chk("burst_data", 32'(cap_d[i]), 32'(102 + i));
         chk("burst_last", 32'(cap_l[i]), 32'(i == 3));
      end

      clear_caps();
      send(1, 5, 0, 18'h2A5A5);
      wait_n(4);
      chk("wr_strobes", 32'(cap_w.size()), 1);
      chk("wr_adrs", 32'(cap_w[0]), 5);
      chk("wr_no_re", 32'(cap_a.size()), 0);

      clear_caps();
      send(0, 5, 0, '0);
      wait_n(6);
      chk("rd1_beats", 32'(cap_d.size()), 1);
      chk("rd1_data", 32'(cap_d[0]), 32'h2A5A5);
      chk("rd1_last", 32'(cap_l[0]), 1);

      clear_caps();
      send(0, 13'h1FFE, 3, '0);
      wait_n(10);
      chk("wrap_issues", 32'(cap_a.size()), 4);
      chk("wrap_a0", 32'(cap_a[0]), 32'h1FFE);
      chk("wrap_a1", 32'(cap_a[1]), 32'h1FFF);
      chk("wrap_a2", 32'(cap_a[2]), 32'h0000);
      chk("wrap_a3", 32'(cap_a[3]), 32'h0001);

      send(1, 20, 0, 18'h3FFFF);
      send(0, 18, 7, '0);
      send(1, 9, 0, 18'h00123);
      send(0, 9, 0, '0);
      wait_n(12);

      send(0, 16, 7, '0);
      clear_caps();
      wait_n(2);
      rst = 1'b1;
      wait_n(2);
      rst = 1'b0;
      wait_n(12);
      chk("rst_no_rsp", 32'(cap_d.size()), 0);

      send(0, 7, 1, '0);
      wait_n(8);

`ifdef MEM_ACC_BOUNDS_EN
      clear_caps();
      send(0, 11, 3, '0);
      wait_n(10);
      chk("bnd_issues", 32'(cap_a.size()), 2);
      chk("bnd_a0", 32'(cap_a[0]), 11);
      chk("bnd_a1", 32'(cap_a[1]), 12);
      chk("bnd_d2", 32'(cap_d[2]), 0);
      chk("bnd_e2", 32'(cap_e[2]), 1);
      chk("bnd_e3", 32'(cap_e[3]), 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator-side controller that drives the single-port data memory's read/write strobes, address and write data from a processor-side request handshake. It sequences single-word writes and 1–8 word incrementing read bursts. It respects the memory's registered one-cycle read latency and never asserts read and write together. It sits between the processor load/store path and the data memory.

Parameters:
ADDR_W, 13, memory address width
DATA_W, 18, memory data width
MEM_DEPTH, 13, number of implemented memory words (used only by bounds check)
MAX_LEN, 8, maximum read burst length in words

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  start address
req_len  in  3  read burst length minus 1 (0..7); ignored for writes
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read beat valid (one-cycle pulse per beat)
rsp_data  out  DATA_W  read beat data
rsp_last  out  1  final beat of burst, qualified by rsp_valid
rsp_err  out  1  beat was out of range (MEM_ACC_BOUNDS_EN only; else tied 0)
wr_done  out  1  one-cycle pulse when a write has been issued
mem_re  out  1  memory read enable
mem_we  out  1  memory write enable
mem_adrs  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory registered read data

Behaviour:
- Reset: async, active-high. All outputs = 0, state = IDLE, counters cleared. Any in-flight burst is discarded with no rsp_valid or wr_done afterwards. req_ready = 0 while rst is high.
- States: IDLE, RD_ISSUE, RD_DRAIN, WR.
- IDLE: req_ready = 1. On req_valid && req_ready, latch we/addr/len/wdata. Go to WR if we = 1, else RD_ISSUE. req_ready = 0 in every other state.
- WR (1 cycle): mem_we = 1, mem_re = 0, mem_adrs = latched addr, mem_wdata = latched data. Next state IDLE. wr_done = 1 in the following cycle.
- RD_ISSUE: one beat per cycle. mem_re = 1, mem_adrs = start + beat index, with index counting 0..len. Address wraps mod 2^ADDR_W. After issuing beat len, go to RD_DRAIN.
- Read latency: beat issued in cycle C has mem_rdata valid in C+1. It is registered into rsp_data, and rsp_valid = 1 in C+2. Back-to-back beats give back-to-back rsp_valid. rsp_last is asserted with the beat whose index = len.
- RD_DRAIN: no strobes. Stay until rsp_last has been registered, i.e. 2 cycles after the last issue, then IDLE. The first new request is accepted in the cycle after rsp_last is output.
- rsp has no backpressure; the consumer must take each beat.
- mem_re and mem_we are never both 1. Both are 0 in IDLE and RD_DRAIN. mem_wdata holds its last value when not writing.
- len = 0 gives a single-beat read. rsp_valid and rsp_last appear together 2 cycles after issue.

Optional Feature:
MEM_ACC_BOUNDS_EN
- Defined: a beat whose address is ≥ MEM_DEPTH suppresses the memory strobe (mem_re/mem_we stay 0) but keeps the same timing. A suppressed read beat returns rsp_data = 0 and rsp_err = 1. A suppressed write still pulses wr_done, with rsp_err = 1 in the same cycle.
- Undefined: no check is made, all addresses go to memory, and rsp_err is tied 0.

Decomposition:
- Package mem_acc_pkg: ADDR_W, DATA_W, MEM_DEPTH, MAX_LEN, LEN_W = 3, state enum {IDLE, RD_ISSUE, RD_DRAIN, WR}.
- Sub-module mem_acc_rsp_pipe: 2-stage shift of {valid, last, err} aligned to the memory latency, plus the rsp_data capture register.

Test Plan:
- Write addr 5, data 18'h2A5A5 -> mem_we = 1 with adrs 5 for one cycle; wr_done in the next cycle; mem_re stays 0 throughout.
- Read addr 5, len 0 after that write -> mem_re one cycle; rsp_valid = rsp_last = 1 two cycles later with rsp_data = 18'h2A5A5.
- Burst read addr 2, len 3, memory preloaded with k + 100 at address k -> 4 consecutive rsp_valid with data 102, 103, 104, 105; rsp_last only on 105; req_ready back 1 cycle after.
- Burst read addr 13'h1FFE, len 3 -> mem_adrs 1FFE, 1FFF, 0000, 0001.
- Assert rst during beat 2 of a len-7 burst -> all outputs 0 immediately; no further rsp_valid; req_ready = 1 the first cycle after rst falls.
- With MEM_ACC_BOUNDS_EN, read addr 11, len 3 -> mem_re only for 11 and 12; beats for 13 and 14 give rsp_data = 0 and rsp_err = 1.
